// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, ctrl opcode encoding, compare encoding.
package alu_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned CNT_W   = 6;
   localparam int unsigned CTRL_W  = 4;
   localparam int unsigned COMP_W  = 2;

   typedef enum logic [CTRL_W-1:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_XOR  = 4'b0010,
      OP_NOR  = 4'b0011,
      OP_ADD  = 4'b0100,
      OP_SUB  = 4'b0101,
      OP_SLT  = 4'b0110,
      OP_SLTU = 4'b0111,
      OP_SLL  = 4'b1000,
      OP_SRL  = 4'b1001,
      OP_SRA  = 4'b1010,
      OP_LUI  = 4'b1011,
      OP_DIV  = 4'b1100,
      OP_DIVU = 4'b1101,
      OP_ZERO = 4'b1110,
      OP_PASS = 4'b1111
   } ctrl_e;

   localparam logic [COMP_W-1:0] COMP_EQ = 2'b00;
   localparam logic [COMP_W-1:0] COMP_LT = 2'b01;
   localparam logic [COMP_W-1:0] COMP_GT = 2'b10;

   // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring radix-2 divider, one quotient bit per clock; divrst low captures operands.
module alu_divider
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              divrst,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              is_signed,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder,
   output logic              done
);

   logic [DATA_W-1:0] dvsr;
   logic [DATA_W-1:0] quo_w;
   logic [DATA_W-1:0] rem_w;
   logic              sign_q;
   logic              sign_r;
   logic              dbz;
   logic [CNT_W-1:0]  count;

   logic              a_neg;
   logic              b_neg;
   logic [DATA_W:0]   shifted;
   logic              ge;
   logic [DATA_W-1:0] rem_nx;
   logic [DATA_W-1:0] quo_nx;
   logic [DATA_W-1:0] q_final;
   logic [DATA_W-1:0] r_final;

   // One restoring step plus the signed fix-up applied on the last step.
   always_comb begin
      a_neg   = is_signed & a[DATA_W-1];
      b_neg   = is_signed & b[DATA_W-1];
      shifted = {rem_w, quo_w[DATA_W-1]};
      ge      = (shifted >= {1'b0, dvsr});
      rem_nx  = ge ? DATA_W'(shifted - {1'b0, dvsr}) : shifted[DATA_W-1:0];
      quo_nx  = {quo_w[DATA_W-2:0], ge};
      q_final = dbz ? '1 : cond_neg(quo_nx, sign_q);
      r_final = cond_neg(rem_nx, sign_r);
   end

   always_ff @(posedge clk) begin
      if (!divrst) begin
         dvsr      <= cond_neg(b, b_neg);
         quo_w     <= cond_neg(a, a_neg);
         rem_w     <= '0;
         sign_q    <= a_neg ^ b_neg;
         sign_r    <= a_neg;
         dbz       <= (b == '0);
         count     <= '0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else if (!done) begin
         quo_w <= quo_nx;
         rem_w <= rem_nx;
         count <= count + CNT_W'(1);
         if (count == CNT_W'(DATA_W - 1)) begin
            done      <= 1'b1;
            quotient  <= q_final;
            remainder <= r_final;
         end
      end
   end

endmodule

// File: rtl/alu.sv
// 32-bit ALU: combinational logic/arith/shift ops, signed compare, multi-cycle divider.
module alu
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              divrst,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] out,
   output logic [DATA_W-1:0] rem,
   output logic              done,
   output logic [COMP_W-1:0] comp
);

   ctrl_e              op;
   logic [SHAMT_W-1:0] shamt;
   logic [DATA_W-1:0]  quotient;
   logic               is_signed;

   assign op        = ctrl_e'(ctrl);
   assign shamt     = a[SHAMT_W-1:0];
   assign is_signed = ~ctrl[0];

   alu_divider u_divider (
      .clk       (clk),
      .divrst    (divrst),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .quotient  (quotient),
      .remainder (rem),
      .done      (done)
   );

   // Result select; OP_ZERO falls through to the default.
   always_comb begin
      out = '0;
      case (op)
         OP_AND:  out = a & b;
         OP_OR:   out = a | b;
         OP_XOR:  out = a ^ b;
         OP_NOR:  out = ~(a | b);
         OP_ADD:  out = a + b;
         OP_SUB:  out = a - b;
         OP_SLT:  out = DATA_W'($signed(a) < $signed(b));
         OP_SLTU: out = DATA_W'(a < b);
         OP_SLL:  out = b << shamt;
         OP_SRL:  out = b >> shamt;
         OP_SRA:  out = $signed(b) >>> shamt;
         OP_LUI:  out = {b[15:0], 16'h0000};
         OP_DIV,
         OP_DIVU: out = done ? quotient : '0;
         OP_PASS: out = a;
         default: out = '0;
      endcase
   end

   always_comb begin
      comp = COMP_GT;
      if (a == b)
         comp = COMP_EQ;
      else if ($signed(a) < $signed(b))
         comp = COMP_LT;
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: random + directed stimulus against a behavioural model.
module tb_alu;

   logic        clk = 1'b0;
   logic        divrst = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [3:0]  ctrl = '0;
   logic [31:0] out;
   logic [31:0] rem;
   logic        done;
   logic [1:0]  comp;

   int errors = 0;
   int checks = 0;

   alu dut (
      .clk    (clk),
      .divrst (divrst),
      .a      (a),
      .b      (b),
      .ctrl   (ctrl),
      .out    (out),
      .rem    (rem),
      .done   (done),
      .comp   (comp)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_comb(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] r;
      int sh;
      sh = int'(x % 32);
      case (c)
         4'd0:  return x & y;
         4'd1:  return x | y;
         4'd2:  return x ^ y;
         4'd3:  return ~(x | y);
         4'd4:  return 32'((64'(x) + 64'(y)) % 64'h1_0000_0000);
         4'd5:  return 32'((64'(x) + 64'h1_0000_0000 - 64'(y)) % 64'h1_0000_0000);
         4'd6:  return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
         4'd7:  return (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
         4'd8:  return 32'((64'(y) * (64'd1 << sh)) % 64'h1_0000_0000);
         4'd9:  return 32'(64'(y) / (64'd1 << sh));
         4'd10: begin
            r = y;
            repeat (sh) r = {r[31], r[31:1]};
            return r;
         end
         4'd11: return 32'((64'(y) * 64'd65536) % 64'h1_0000_0000);
         4'd15: return x;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [1:0] model_comp(input logic [31:0] x, input logic [31:0] y);
      if (int'(x) == int'(y)) return 2'b00;
      if (int'(x) < int'(y))  return 2'b01;
      return 2'b10;
   endfunction

   task automatic model_div(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                            output logic [31:0] q, output logic [31:0] r);
      if (y == 0) begin
         q = 32'hFFFF_FFFF;
         r = x;
      end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'h0;
      end else if (sgn) begin
         q = 32'(int'(x) / int'(y));
         r = 32'(int'(x) % int'(y));
      end else begin
         q = x / y;
         r = x % y;
      end
   endtask

   // Capture operands on one edge, release, then run 32 edges checking done timing and results.
   task automatic run_div(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
      logic [31:0] eq, er;
      model_div(x, y, (c == 4'b1100), eq, er);
      a = x; b = y; ctrl = c; divrst = 1'b0;
      @(posedge clk); #1;
      divrst = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk); #1;
         if (i == 31) begin
            checks++;
            if (done !== 1'b0 || out !== 32'h0) begin
               errors++;
               $display("FAIL %s early: done=%b out=%h, required done=0 out=0", tag, done, out);
            end
         end
      end
      checks++;
      if (done !== 1'b1 || out !== eq || rem !== er) begin
         errors++;
         $display("FAIL %s result: done=%b out=%h rem=%h, required done=1 out=%h rem=%h",
                  tag, done, out, rem, eq, er);
      end
   endtask

   task automatic test_reset();
      a = 32'h0000_0064; b = 32'h0000_0007; ctrl = 4'b1100; divrst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || rem !== 32'h0 || out !== 32'h0) begin
         errors++;
         $display("FAIL reset: done=%b rem=%h out=%h, required 0/0/0", done, rem, out);
      end
      divrst = 1'b1;
   endtask

   task automatic test_comb_directed();
      a = 32'hFFFF_FFFF; b = 32'h0000_0001;
      ctrl = 4'b0100; #1;
      checks++; if (out !== 32'h0) begin errors++; $display("FAIL add_wrap: got %h want 00000000", out); end
      ctrl = 4'b0101; #1;
      checks++; if (out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub: got %h want fffffffe", out); end
      ctrl = 4'b0110; #1;
      checks++; if (out !== 32'h1) begin errors++; $display("FAIL slt: got %h want 1", out); end
      ctrl = 4'b0111; #1;
      checks++; if (out !== 32'h0) begin errors++; $display("FAIL sltu: got %h want 0", out); end
      checks++; if (comp !== 2'b01) begin errors++; $display("FAIL comp_lt: got %b want 01", comp); end
      a = 32'h4; b = 32'h8000_0000; ctrl = 4'b1010; #1;
      checks++; if (out !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h want f8000000", out); end
      a = 32'h1234_5678; b = 32'h1234_5678; ctrl = 4'b1110; #1;
      checks++; if (comp !== 2'b00) begin errors++; $display("FAIL comp_eq: got %b want 00", comp); end
      checks++; if (out !== 32'h0) begin errors++; $display("FAIL zero_op: got %h want 0", out); end
      a = 32'h7FFF_FFFF; b = 32'h8000_0000; #1;
      checks++; if (comp !== 2'b10) begin errors++; $display("FAIL comp_gt: got %b want 10", comp); end
   endtask

   task automatic test_comb_random();
      logic [3:0] c;
      for (int i = 0; i < 300; i++) begin
         do c = 4'($urandom_range(0, 15)); while (c == 4'b1100 || c == 4'b1101);
         a = $urandom; b = $urandom;
         if (i % 7 == 0) b = a;
         if (i % 5 == 0) a = a & 32'h0000_003F;
         ctrl = c; #1;
         checks++;
         if (out !== model_comb(c, a, b) || comp !== model_comp(a, b)) begin
            errors++;
            $display("FAIL comb_rand ctrl=%b a=%h b=%h: out=%h comp=%b, required out=%h comp=%b",
                     c, a, b, out, comp, model_comb(c, a, b), model_comp(a, b));
         end
         #4;
      end
   endtask

   task automatic test_div_directed();
      run_div("sdiv_f0", 32'hF000_0000, 32'h0000_0002, 4'b1100);
      checks++; if (comp !== 2'b01) begin errors++; $display("FAIL sdiv_comp: got %b want 01", comp); end
      run_div("udiv_f0", 32'hF000_0000, 32'h0000_0002, 4'b1101);
      run_div("sdiv_m7", 32'hFFFF_FFF9, 32'h0000_0002, 4'b1100);
      run_div("udiv_dbz", 32'h1234_5678, 32'h0, 4'b1101);
      run_div("sdiv_dbz_neg", 32'h8765_4321, 32'h0, 4'b1100);
      run_div("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 4'b1100);
      run_div("udiv_big", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1101);
   endtask

   task automatic test_div_random();
      logic [31:0] x, y;
      logic [3:0]  c;
      for (int i = 0; i < 24; i++) begin
         x = $urandom; y = $urandom;
         if (i % 3 == 0) y = y >> $urandom_range(8, 31);
         if (i % 8 == 0) y = 32'h0;
         c = (i % 2 == 0) ? 4'b1100 : 4'b1101;
         run_div("div_rand", x, y, c);
      end
   endtask

   task automatic test_restart();
      a = 32'd100; b = 32'd7; ctrl = 4'b1101; divrst = 1'b0;
      @(posedge clk); #1;
      divrst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      a = 32'd50; b = 32'd5; divrst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL restart_drop: done=%b want 0", done); end
      divrst = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk); #1;
         if (i == 31) begin
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL restart_early: done=%b want 0", done); end
         end
      end
      checks++;
      if (done !== 1'b1 || out !== 32'd10 || rem !== 32'd0) begin
         errors++;
         $display("FAIL restart_result: done=%b out=%h rem=%h, required 1/0000000a/0", done, out, rem);
      end
   endtask

   task automatic test_operand_change_and_hold();
      logic [31:0] eq, er;
      model_div(32'hC000_0001, 32'h0000_0013, 1'b1, eq, er);
      a = 32'hC000_0001; b = 32'h0000_0013; ctrl = 4'b1100; divrst = 1'b0;
      @(posedge clk); #1;
      divrst = 1'b1;
      repeat (32) begin
         a = $urandom; b = $urandom; ctrl = 4'($urandom_range(0, 15));
         @(posedge clk); #1;
      end
      ctrl = 4'b1100; #1;
      checks++;
      if (done !== 1'b1 || out !== eq || rem !== er) begin
         errors++;
         $display("FAIL operand_change: done=%b out=%h rem=%h, required 1/%h/%h", done, out, rem, eq, er);
      end
      repeat (6) begin
         a = $urandom; b = $urandom;
         @(posedge clk); #1;
      end
      checks++;
      if (done !== 1'b1 || out !== eq || rem !== er) begin
         errors++;
         $display("FAIL hold: done=%b out=%h rem=%h, required 1/%h/%h", done, out, rem, eq, er);
      end
      ctrl = 4'b0000; #1;
      checks++;
      if (rem !== er) begin errors++; $display("FAIL rem_any_ctrl: got %h want %h", rem, er); end
   endtask

   initial begin
      test_reset();
      test_comb_directed();
      test_comb_random();
      test_div_directed();
      test_div_random();
      test_restart();
      test_operand_change_and_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
- REQ-001 SHALL have no parameters; the datapath width is fixed at 32 bits.
- REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003 Port: divrst  input  1  synchronous active-low reset. 0 at a rising edge clears divider state and loads the divide operands; the division runs while it is 1.
- REQ-004 Port: a  input  32  operand A; dividend for division.
- REQ-005 Port: b  input  32  operand B; divisor for division.
- REQ-006 Port: ctrl  input  4  operation select.
- REQ-007 Port: out  output  32  result; quotient for division ops.
- REQ-008 Port: rem  output  32  division remainder.
- REQ-009 Port: done  output  1  division result valid.
- REQ-010 Port: comp  output  2  signed compare of a vs b.

Function
- REQ-011 ctrl decode, combinational ops:
  - 0000 AND; 0001 OR; 0010 XOR; 0011 NOR.
  - 0100 a+b, wrap mod 2^32, no overflow flag.
  - 0101 a-b, wrap.
  - 0110 SLT signed, result 1/0; 0111 SLTU unsigned, result 1/0.
  - 1000 b << a[4:0]; 1001 b >> a[4:0] logical; 1010 b >>> a[4:0] arithmetic.
  - 1011 {b[15:0],16'h0}.
  - 1110 out=0; 1111 out=a.
- REQ-012 ctrl decode, division ops: 1100 signed divide; 1101 unsigned divide.
- REQ-013 Non-division ops SHALL be purely combinational with zero latency, independent of clk and divrst.
- REQ-014 comp SHALL be 2'b00 if a==b, 2'b01 if a<b (signed), 2'b10 if a>b (signed); never 2'b11. Combinational for all ctrl values.
- REQ-015 Divider: restoring radix-2, one quotient bit per clock.
- REQ-016 Operand capture: a rising edge with divrst=0 latches |a|, |b| and the operand signs (signedness per ctrl[0] at that edge), clears the iteration counter, and clears done.
- REQ-017 Iteration: each rising edge with divrst=1 and done=0 performs one iteration.
- REQ-018 Completion: the 32nd such edge sets done=1; latency is 32 cycles after divrst release.
- REQ-019 done SHALL stay 1, and quotient/remainder SHALL hold, until the next edge with divrst=0.
- REQ-020 Changes on a, b or ctrl after capture SHALL NOT affect the running division.
- REQ-021 Signed result sign: quotient truncates toward zero; the remainder takes the sign of the dividend.
- REQ-022 Divide by zero (b=0 at capture): quotient=32'hFFFFFFFF, remainder=dividend, done after the normal 32 cycles.
- REQ-023 Signed overflow: 32'h80000000 / 32'hFFFFFFFF gives quotient 32'h80000000, remainder 0.
- REQ-024 out for ctrl=1100/1101: quotient when done=1, else 0.
- REQ-025 rem SHALL always drive the divider remainder register, independent of ctrl.
- REQ-026 divrst=0 asserted mid-division SHALL abort the division and restart it with the current operands.

Reset
- REQ-027 A rising edge with divrst=0 SHALL set done=0, the quotient register to 0, the remainder register to 0, and the counter to 0.
- REQ-028 Before the first such edge the divider state is undefined; combinational outputs are valid immediately.

Structure
- REQ-029 Shared package alu_pkg SHALL hold the ctrl opcode enum (all 16 codes) and the comp encoding constants.
- REQ-030 The divider SHALL be one sub-module, alu_divider (clk, divrst, a, b, is_signed -> quotient, remainder, done); all other logic is top-level combinational.

Verification
- REQ-031 Signed divide, 0xF0000000 / 0x00000002 (ctrl 1100):
  - Stimulus: one edge with divrst=0, then divrst=1.
  - Response: done rises at the 32nd edge; out=0xF8000000; rem=0; comp=01.
- REQ-032 Unsigned divide, 0xF0000000 / 0x00000002 (ctrl 1101):
  - Response: out=0x78000000, rem=0.
  - Signed divide -7 / 2: out=0xFFFFFFFD, rem=0xFFFFFFFF.
- REQ-033 Divide by zero, 0x12345678 / 0:
  - Response: out=0xFFFFFFFF, rem=0x12345678, done after 32 cycles.
  - Signed 0x80000000 / 0xFFFFFFFF: out=0x80000000, rem=0.
- REQ-034 Restart mid-division:
  - Stimulus: start 100/7; at cycle 10 drive divrst=0 with 50/5.
  - Response: done drops; after 32 cycles out=10, rem=0.
- REQ-035 Combinational sweep, a=0xFFFFFFFF, b=0x00000001:
  - ADD=0; SUB=0xFFFFFFFE; SLT=1; SLTU=0.
  - SRA of b=0x80000000 by 4 gives 0xF8000000.
  - comp=01; with a=b, comp=00.
